// File: rtl/multicycle_control.sv
// multicycle_control: lw/sw multicycle FSM with memory-handshake timeout, retire counter and sticky error state
module multicycle_control #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] ins,
  input  logic        mem_ready,
  output logic        memRead,
  output logic        memWrite,
  output logic        iOrD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        regWriteEnable,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [4:0]  alu_ctrl,
  output logic        illegal,
  output logic        timeout_err,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, ERROR} state_t;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [15:0] cnt_q, cnt_d;
  logic terr_q, terr_d;
  logic waiting, timed_out, retire;
  logic [5:0] opcode;
  logic unused_ins;
  assign opcode = ins[31:26];
  assign unused_ins = ^ins[25:0];
  always_comb begin
    state_d = state_q;
    memRead = 1'b0;
    memWrite = 1'b0;
    iOrD = 1'b0;
    irWrite = 1'b0;
    pcWrite = 1'b0;
    regWriteEnable = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = 2'b00;
    alu_ctrl = 5'b00000;
    illegal = 1'b0;
    retire = 1'b0;
    waiting = state_q inside {FETCH, MEMRD, MEMWR};
    // This cycle's increment would bring the wait count to TIMEOUT; a ready handshake still wins
    timed_out = waiting && !mem_ready && wait_q == WAIT_LAST;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        alu_ctrl = 5'b00010;
        irWrite = mem_ready;
        pcWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        illegal = !(opcode == OP_LW || opcode == OP_SW);
        state_d = !illegal ? MEMADR : run ? FETCH : IDLE;
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        alu_ctrl = 5'b00010;
        state_d = opcode == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memRead = 1'b1;
        iOrD = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        regWriteEnable = 1'b1;
        retire = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iOrD = 1'b1;
        retire = mem_ready;
        if (mem_ready) state_d = run ? FETCH : IDLE;
      end
      default: state_d = ERROR;
    endcase
    if (timed_out) state_d = ERROR;
    wait_d = state_d != state_q ? 8'd0 : (waiting && !mem_ready) ? wait_q + 8'd1 : wait_q;
    cnt_d = cnt_q + 16'(retire);
    terr_d = terr_q | timed_out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q <= 8'd0;
      cnt_q <= 16'd0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      cnt_q <= cnt_d;
      terr_q <= terr_d;
    end
  end
  assign state = state_q;
  assign instr_count = cnt_q;
  assign timeout_err = terr_q;
endmodule
